// File: rtl/sliding_window_3x3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sw_pkg                                                       |
// | Description : Shared constants and helpers for the 3x3 sliding window.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sw_pkg;

  // Window edge length and number of taps in one window.
  localparam int K        = 3;
  localparam int WIN_TAPS = K * K;

  // Flat tap index of window row r, column c (k=0 is top-left).
  function automatic int tap(input int r, input int c);
    return K * r + c;
  endfunction

  // Ceiling log2, never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sliding_window_3x3_line_buffer_row.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : line_buffer_row                                              |
// | Description : One image row of storage, combinational read-before-write.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module line_buffer_row
  import sw_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  // Contents are deliberately not reset; the consumer gates out stale rows.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // The read returns the value stored before this cycle's write lands.
  assign rdata = mem_q[addr];

  // Registered write of the new column value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sliding_window_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sliding_window_3x3                                           |
// | Description : Raster pixel stream in, 3x3 neighbourhood windows out, with  |
// |               valid/ready handshakes and backpressure on both sides.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sliding_window_3x3
  import sw_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIN_TAPS*DATA_W-1:0] win_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       win_last
);

  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col_ptr_q, col_ptr_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;

  // Working window (always shifting) and the registered output copy.
  logic [WIN_TAPS*DATA_W-1:0] win_q, win_d;
  logic [WIN_TAPS*DATA_W-1:0] win_data_q, win_data_d;
  logic                       win_valid_q, win_valid_d;
  logic                       win_last_q, win_last_d;

  logic              accept;
  logic              emit;
  logic [DATA_W-1:0] lb_a_rdata;  // same column, previous row
  logic [DATA_W-1:0] lb_b_rdata;  // same column, two rows up

  // A pending window that the consumer is not taking blocks the input.
  assign in_ready  = !win_valid_q || win_ready;
  assign accept    = in_valid && in_ready;
  assign emit      = accept && (row_cnt_q >= ROW_FIRST_WIN) && (col_ptr_q >= COL_FIRST_WIN);

  assign win_data  = win_data_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

  // Row r-1 buffer takes the incoming pixel; its old value ages into row r-2.
  line_buffer_row #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb_a (
    .clk   (clk),
    .we    (accept),
    .addr  (col_ptr_q),
    .wdata (in_data),
    .rdata (lb_a_rdata)
  );

  line_buffer_row #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb_b (
    .clk   (clk),
    .we    (accept),
    .addr  (col_ptr_q),
    .wdata (lb_a_rdata),
    .rdata (lb_b_rdata)
  );

  // Next-state: window shift, raster counters and the output register.
  always_comb begin
    col_ptr_d   = col_ptr_q;
    row_cnt_d   = row_cnt_q;
    win_d       = win_q;
    win_data_d  = win_data_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (accept) begin
      for (int r = 0; r < K; r++) begin
        win_d[tap(r, 0)*DATA_W +: DATA_W] = win_q[tap(r, 1)*DATA_W +: DATA_W];
        win_d[tap(r, 1)*DATA_W +: DATA_W] = win_q[tap(r, 2)*DATA_W +: DATA_W];
      end
      win_d[tap(0, 2)*DATA_W +: DATA_W] = lb_b_rdata;
      win_d[tap(1, 2)*DATA_W +: DATA_W] = lb_a_rdata;
      win_d[tap(2, 2)*DATA_W +: DATA_W] = in_data;

      if (col_ptr_q == COL_LAST) begin
        col_ptr_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_ptr_d = col_ptr_q + CW'(1);
      end
    end

    // Only windows fully inside the current frame are presented.
    if (emit) begin
      win_valid_d = 1'b1;
      win_data_d  = win_d;
      win_last_d  = (row_cnt_q == ROW_LAST) && (col_ptr_q == COL_LAST);
    end else if (accept || win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // State register with synchronous reset; line buffers are left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_ptr_q   <= '0;
      row_cnt_q   <= '0;
      win_q       <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_ptr_q   <= col_ptr_d;
      row_cnt_q   <= row_cnt_d;
      win_q       <= win_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sliding_window_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sliding_window_3x3                                        |
// | Description : Self-checking bench for sliding_window_3x3 (4x4 and 10x10).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sliding_window_3x3;

  localparam int DW   = 8;
  localparam int TAPS = 9;
  localparam int H4   = 4;
  localparam int W4   = 4;
  localparam int H10  = 10;
  localparam int W10  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [DW-1:0]      in_data4   = '0;
  logic               in_valid4  = 1'b0;
  logic               in_ready4;
  logic [TAPS*DW-1:0] win_data4;
  logic               win_valid4;
  logic               win_ready4 = 1'b1;
  logic               win_last4;

  logic [DW-1:0]      in_data10  = '0;
  logic               in_valid10 = 1'b0;
  logic               in_ready10;
  logic [TAPS*DW-1:0] win_data10;
  logic               win_valid10;
  logic               win_ready10 = 1'b1;
  logic               win_last10;

  int total = 0;
  int bad   = 0;
  bit done10;

  logic [TAPS*DW:0] got4[$];
  logic [TAPS*DW:0] got10[$];
  logic [DW-1:0]    pix10[H10][W10];

  always #5 clk = ~clk;

  sliding_window_3x3 #(.DATA_W(DW), .IMG_W(W4), .IMG_H(H4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .win_data  (win_data4),
    .win_valid (win_valid4),
    .win_ready (win_ready4),
    .win_last  (win_last4)
  );

  sliding_window_3x3 #(.DATA_W(DW), .IMG_W(W10), .IMG_H(H10)) u_dut10 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data10),
    .in_valid  (in_valid10),
    .in_ready  (in_ready10),
    .win_data  (win_data10),
    .win_valid (win_valid10),
    .win_ready (win_ready10),
    .win_last  (win_last10)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference window for the 4x4 pattern image: pixel = base + row*16 + col.
  function automatic logic [TAPS*DW-1:0] exp4(input int base, input int r, input int c);
    logic [TAPS*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = DW'(base + (r-2+i)*16 + (c-2+j));
    return w;
  endfunction

  // Reference window for the random 10x10 image.
  function automatic logic [TAPS*DW-1:0] exp10(input int r, input int c);
    logic [TAPS*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = pix10[r-2+i][c-2+j];
    return w;
  endfunction

  // Record every window handed off at the coming edge (inputs are stable mid-cycle).
  always @(negedge clk) begin
    if (!rst && win_valid4 && win_ready4)   got4.push_back({win_last4, win_data4});
    if (!rst && win_valid10 && win_ready10) got10.push_back({win_last10, win_data10});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid4  = 1'b0;
    in_valid10 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got4.delete();
    got10.delete();
  endtask

  task automatic push4(input int val);
    int n;
    n = 0;
    in_data4  = DW'(val);
    in_valid4 = 1'b1;
    @(negedge clk);
    while (!in_ready4) begin
      n++;
      if (n > 200) begin
        check_val("push4_timeout", 1, 0);
        in_valid4 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
  endtask

  task automatic push10(input logic [DW-1:0] val);
    int n;
    n = 0;
    in_data10  = val;
    in_valid10 = 1'b1;
    @(negedge clk);
    while (!in_ready10) begin
      n++;
      if (n > 200) begin
        check_val("push10_timeout", 1, 0);
        in_valid10 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid10 = 1'b0;
  endtask

  // Whole 4x4 frame; optionally checks win_valid/win_data right after each accept.
  task automatic push_frame4(input int base, input bit gaps, input bit chkpos);
    for (int r = 0; r < H4; r++) begin
      for (int c = 0; c < W4; c++) begin
        push4(base + r*16 + c);
        if (chkpos) begin
          check_val("valid_after_accept", win_valid4, (r >= 2 && c >= 2));
          if (r >= 2 && c >= 2) check_val("win_after_accept", win_data4, exp4(base, r, c));
        end
        if (gaps) idle(1);
      end
    end
  endtask

  task automatic check_frames4(input string tag, input int nframes);
    int idx;
    idx = 0;
    check_val({tag, "_count"}, got4.size(), 4*nframes);
    for (int f = 0; f < nframes; f++)
      for (int r = 2; r < H4; r++)
        for (int c = 2; c < W4; c++) begin
          if (idx < got4.size()) begin
            check_val({tag, "_data"}, got4[idx][TAPS*DW-1:0], exp4(f*128, r, c));
            check_val({tag, "_last"}, got4[idx][TAPS*DW], (r == H4-1 && c == W4-1));
          end
          idx++;
        end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lasts;
    int idx;

    // Reset state
    do_reset();
    @(negedge clk);
    check_val("rst_in_ready", in_ready4, 1);
    check_val("rst_win_valid", win_valid4, 0);
    check_val("rst_win_last", win_last4, 0);
    check_val("rst_win_data", win_data4, 0);
    check_val("rst_win_valid10", win_valid10, 0);

    // 1: single frame, win_ready held high
    do_reset();
    win_ready4 = 1'b1;
    push_frame4(0, 1'b0, 1'b1);
    idle(3);
    check_frames4("s1", 1);

    // 2: backpressure for 5 cycles after the first window
    do_reset();
    win_ready4 = 1'b1;
    for (int i = 0; i <= 10; i++) push4((i / W4) * 16 + (i % W4));
    win_ready4 = 1'b0;
    fork
      begin
        for (int i = 11; i < H4*W4; i++) push4((i / W4) * 16 + (i % W4));
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check_val("bp_in_ready", in_ready4, 0);
          check_val("bp_valid", win_valid4, 1);
          check_val("bp_data", win_data4, exp4(0, 2, 2));
        end
        @(posedge clk);
        #1;
        win_ready4 = 1'b1;
      end
    join
    idle(4);
    check_frames4("s2", 1);

    // 3: input gaps every other cycle
    do_reset();
    win_ready4 = 1'b1;
    push_frame4(0, 1'b1, 1'b1);
    idle(3);
    check_frames4("s3", 1);

    // 4: two frames back to back
    do_reset();
    push_frame4(0, 1'b0, 1'b0);
    push_frame4(128, 1'b0, 1'b1);
    idle(3);
    check_frames4("s4", 2);

    // 5: reset after pixel 0x21, then a fresh frame
    do_reset();
    for (int i = 0; i < 10; i++) push4((i / W4) * 16 + (i % W4));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("s5_valid_after_rst", win_valid4, 0);
    check_val("s5_ready_after_rst", in_ready4, 1);
    got4.delete();
    push_frame4(0, 1'b0, 1'b0);
    idle(3);
    check_frames4("s5", 1);

    // 6: 10x10 random pixels, random gaps and random win_ready
    do_reset();
    for (int r = 0; r < H10; r++)
      for (int c = 0; c < W10; c++)
        pix10[r][c] = DW'($urandom);
    done10 = 1'b0;
    fork
      begin
        for (int r = 0; r < H10; r++)
          for (int c = 0; c < W10; c++) begin
            push10(pix10[r][c]);
            if ($urandom_range(0, 3) == 0) idle(1);
          end
        done10 = 1'b1;
      end
      begin
        while (!done10) begin
          win_ready10 = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        win_ready10 = 1'b1;
      end
    join
    idle(5);
    check_val("s6_count", got10.size(), (H10-2)*(W10-2));
    lasts = 0;
    idx   = 0;
    for (int r = 2; r < H10; r++)
      for (int c = 2; c < W10; c++) begin
        if (idx < got10.size()) begin
          check_val("s6_data", got10[idx][TAPS*DW-1:0], exp10(r, c));
          check_val("s6_last", got10[idx][TAPS*DW], (r == H10-1 && c == W10-1));
          if (got10[idx][TAPS*DW]) lasts++;
        end
        idx++;
      end
    check_val("s6_last_count", lasts, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
